cnt_obi_buf: RTL and testbench
==============================

CNT_OBI_BUF -- requirements
Module: cnt_obi_buf

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; multiple of 8; byte-enable width BW = DW/8.
REQ-003 Parameter DEPTH, default 2, maximum outstanding transactions and response FIFO depth; at least 1.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 s_req_i/s_we_i  in  1/1  upstream OBI request and write enable.
REQ-007 s_be_i/s_addr_i/s_wdata_i  in  BW/AW/DW  upstream byte enables, address, write data.
REQ-008 s_gnt_o  out  1  upstream grant.
REQ-009 s_rvalid_o/s_rdata_o  out  1/DW  upstream response valid and read data.
REQ-010 m_req_o/m_we_o  out  1/1  downstream request and write enable.
REQ-011 m_be_o/m_addr_o/m_wdata_o  out  BW/AW/DW  downstream byte enables, address, write data.
REQ-012 m_gnt_i  in  1  downstream grant.
REQ-013 m_rvalid_i/m_rdata_i  in  1/DW  downstream response valid and read data.
REQ-014 outstanding_o  out  $clog2(DEPTH+1)  current outstanding-transaction count.

Function
REQ-015 Request slot is a 2-state FSM: EMPTY, FULL.
REQ-016 Slot EMPTY: m_req_o=0; s_gnt_o=credit; on s_req_i&&s_gnt_o, capture we/be/addr/wdata and go FULL.
REQ-017 Slot FULL: m_req_o=1 and m_* driven from the slot registers; s_gnt_o=m_gnt_i&&credit.
REQ-018 FULL with m_gnt_i and an upstream handshake in the same cycle: stay FULL and load the new request; m_gnt_i alone: go EMPTY.
REQ-019 Request latency: downstream request is asserted exactly 1 cycle after the upstream handshake; slot contents are held stable while m_req_o=1 and m_gnt_i=0.
REQ-020 credit = (outstanding_q < DEPTH); outstanding_o = outstanding_q.
REQ-021 outstanding_q: +1 on upstream handshake only; -1 on s_rvalid_o only; unchanged when both or neither occur; saturates at 0 and DEPTH.
REQ-022 Response FIFO has DEPTH entries of DW bits, in order: push m_rdata_i on m_rvalid_i; s_rvalid_o = FIFO non-empty; s_rdata_o = head; pop every cycle s_rvalid_o=1 (OBI has no response back-pressure).
REQ-023 Push and pop in the same cycle are both performed; occupancy is unchanged; pointers wrap modulo DEPTH.
REQ-024 m_rvalid_i while FIFO full and not popping: response dropped, FIFO and counter unchanged (unreachable under legal OBI traffic given REQ-020).
REQ-025 Response latency: s_rvalid_o is asserted 1 cycle after m_rvalid_i, unless REQ-031 applies.

Reset
REQ-026 While rst_ni=0: slot EMPTY; FIFO empty; pointers 0; outstanding_q=0.
REQ-027 While rst_ni=0: m_req_o=0, s_gnt_o=0, s_rvalid_o=0, outstanding_o=0, m_*/s_rdata_o=0.
REQ-028 Reset assertion mid-transaction discards the slot and all FIFO contents immediately, without waiting for a clock edge.
REQ-029 Normal operation resumes on the first rising edge after rst_ni deasserts.

Configuration
REQ-030 Macro CNT_OBI_BUF_RSP_BYPASS_EN selects a zero-latency response path.
REQ-031 Defined: when the FIFO is empty and m_rvalid_i=1, s_rvalid_o=1 and s_rdata_o=m_rdata_i in the same cycle; no push occurs.
REQ-032 Defined: when the FIFO is non-empty, the response is pushed as per REQ-022, preserving order.
REQ-033 Undefined: all responses go through the FIFO with 1-cycle latency.

Verification
REQ-034 Single read, addr 0x100, m_gnt_i=1, m_rvalid_i 2 cycles later with rdata 0xDEADBEEF -> m_req_o 1 cycle after upstream handshake; s_rvalid_o with 0xDEADBEEF 1 cycle after m_rvalid_i (0 cycles with bypass); outstanding_o returns 0.
REQ-035 DEPTH=2, m_gnt_i=1, no responses, 3 back-to-back requests -> first 2 granted, s_gnt_o=0 for the third, outstanding_o=2.
REQ-036 m_gnt_i held 0 for 5 cycles with slot FULL, write addr 0x40 data 0x12345678 be 0xF -> m_* stable for all 5 cycles; s_gnt_o=0.
REQ-037 Responses 0x1, 0x2, 0x3 on consecutive cycles with 3 outstanding (DEPTH=4) -> s_rdata_o 0x1, 0x2, 0x3 in order; simultaneous push and pop leave occupancy unchanged.
REQ-038 rst_ni pulled low with slot FULL and 1 FIFO entry -> m_req_o=0, s_rvalid_o=0, outstanding_o=0 immediately.
REQ-039 Full-throughput stream of 16 reads, m_gnt_i=1, fixed 1-cycle response latency, DEPTH=2 -> all 16 upstream responses are delivered in order with no drops.

Source files
------------

// File: rtl/cnt_obi_buf.sv
// -----------------------------------------------------------------------------
// cnt_obi_buf -- single-slot OBI request buffer with outstanding-transaction
// credit counter and in-order response FIFO.
//
// An upstream OBI request is captured into a one-entry slot and presented
// downstream one cycle later. Upstream grants are withheld once DEPTH
// transactions are in flight. Downstream responses are queued in a DEPTH-entry
// FIFO and returned upstream in order; OBI responses cannot be back-pressured,
// so the FIFO head is popped every cycle it is valid.
//
// Configuration macro:
//   CNT_OBI_BUF_RSP_BYPASS_EN  when defined, a response arriving while the FIFO
//                              is empty is forwarded upstream combinationally
//                              (zero latency) instead of being queued.
//
// Parameters:
//   AW     address width
//   DW     data width (multiple of 8); BW = DW/8 byte enables
//   DEPTH  maximum outstanding transactions and response FIFO depth (>= 1)
//
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   s_req_i, s_we_i, s_be_i, s_addr_i,
//   s_wdata_i                              upstream request channel
//   s_gnt_o                                upstream grant
//   s_rvalid_o, s_rdata_o                  upstream response channel
//   m_req_o, m_we_o, m_be_o, m_addr_o,
//   m_wdata_o                              downstream request channel
//   m_gnt_i                                downstream grant
//   m_rvalid_i, m_rdata_i                  downstream response channel
//   outstanding_o                          current outstanding-transaction count
// -----------------------------------------------------------------------------
module cnt_obi_buf #(
   parameter  int unsigned AW    = 32,
   parameter  int unsigned DW    = 32,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned BW    = DW / 8,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   // upstream
   input  logic          s_req_i,
   input  logic          s_we_i,
   input  logic [BW-1:0] s_be_i,
   input  logic [AW-1:0] s_addr_i,
   input  logic [DW-1:0] s_wdata_i,
   output logic          s_gnt_o,
   output logic          s_rvalid_o,
   output logic [DW-1:0] s_rdata_o,
   // downstream
   output logic          m_req_o,
   output logic          m_we_o,
   output logic [BW-1:0] m_be_o,
   output logic [AW-1:0] m_addr_o,
   output logic [DW-1:0] m_wdata_o,
   input  logic          m_gnt_i,
   input  logic          m_rvalid_i,
   input  logic [DW-1:0] m_rdata_i,
   // status
   output logic [CW-1:0] outstanding_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // request slot
   slot_state_e   state_q, state_d;
   logic          we_q, we_d;
   logic [BW-1:0] be_q, be_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;

   // credit counter
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic          credit;
   logic          gnt;
   logic          s_hs;

   // response FIFO
   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign credit = (outstanding_q < CW'(DEPTH));
   assign s_hs   = s_req_i && gnt;

   // ---------------------------------------------------------------------------
   // Request slot FSM
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default at the top;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gnt     = 1'b0;

      case (state_q)
         SLOT_EMPTY: gnt = credit;
         SLOT_FULL: begin
            // A new request may only enter while the current one leaves.
            gnt = m_gnt_i && credit;
            if (m_gnt_i) state_d = SLOT_EMPTY;
         end
         default: state_d = SLOT_EMPTY;
      endcase

      // Handshake overrides the drain: the slot refills in the same cycle.
      if (s_hs) begin
         state_d = SLOT_FULL;
         we_d    = s_we_i;
         be_d    = s_be_i;
         addr_d  = s_addr_i;
         wdata_d = s_wdata_i;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SLOT_EMPTY;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Response FIFO
   // ---------------------------------------------------------------------------
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign pop        = !fifo_empty;

`ifdef CNT_OBI_BUF_RSP_BYPASS_EN
   // Empty FIFO: the response goes straight through and is never stored.
   assign rsp_valid = !fifo_empty || m_rvalid_i;
   assign rsp_data  = fifo_empty ? m_rdata_i : mem_q[rptr_q];
   assign push      = m_rvalid_i && !fifo_empty && (!fifo_full || pop);
`else
   assign rsp_valid = !fifo_empty;
   assign rsp_data  = mem_q[rptr_q];
   assign push      = m_rvalid_i && (!fifo_full || pop);
`endif

   always_comb begin
      wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array has no reset; stale entries are never visible
   // because the read data is qualified by the occupancy count.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= m_rdata_i;
   end

   // ---------------------------------------------------------------------------
   // Outstanding-transaction counter
   // ---------------------------------------------------------------------------
   always_comb begin
      outstanding_d = outstanding_q;
      if (s_hs && !rsp_valid && (outstanding_q != CW'(DEPTH))) begin
         outstanding_d = outstanding_q + 1'b1;
      end else if (!s_hs && rsp_valid && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) outstanding_q <= '0;
      else         outstanding_q <= outstanding_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs. Grant and response valid depend on live inputs, so they are
   // masked by reset directly rather than relying on register state.
   // ---------------------------------------------------------------------------
   assign s_gnt_o       = gnt && rst_ni;
   assign s_rvalid_o    = rsp_valid && rst_ni;
   assign s_rdata_o     = s_rvalid_o ? rsp_data : '0;
   assign m_req_o       = (state_q == SLOT_FULL);
   assign m_we_o        = we_q;
   assign m_be_o        = be_q;
   assign m_addr_o      = addr_q;
   assign m_wdata_o     = wdata_q;
   assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_cnt_obi_buf.sv
// -----------------------------------------------------------------------------
// tb_cnt_obi_buf -- directed self-checking bench for cnt_obi_buf.
// Two instances share all inputs: u_d2 (DEPTH=2) and u_d4 (DEPTH=4); each test
// checks the instance whose depth it targets. Works with or without
// CNT_OBI_BUF_RSP_BYPASS_EN defined (expected response latency follows it).
// -----------------------------------------------------------------------------
module tb_cnt_obi_buf;

`ifdef CNT_OBI_BUF_RSP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        s_req_i, s_we_i;
   logic [3:0]  s_be_i;
   logic [31:0] s_addr_i, s_wdata_i;
   logic        m_gnt_i, m_rvalid_i;
   logic [31:0] m_rdata_i;

   logic        d2_s_gnt_o, d2_s_rvalid_o, d2_m_req_o, d2_m_we_o;
   logic [31:0] d2_s_rdata_o, d2_m_addr_o, d2_m_wdata_o;
   logic [3:0]  d2_m_be_o;
   logic [1:0]  d2_outstanding_o;

   logic        d4_s_gnt_o, d4_s_rvalid_o, d4_m_req_o, d4_m_we_o;
   logic [31:0] d4_s_rdata_o, d4_m_addr_o, d4_m_wdata_o;
   logic [3:0]  d4_m_be_o;
   logic [2:0]  d4_outstanding_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   cnt_obi_buf #(.AW(32), .DW(32), .DEPTH(2)) u_d2 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_req_i(s_req_i), .s_we_i(s_we_i), .s_be_i(s_be_i), .s_addr_i(s_addr_i),
      .s_wdata_i(s_wdata_i), .s_gnt_o(d2_s_gnt_o), .s_rvalid_o(d2_s_rvalid_o),
      .s_rdata_o(d2_s_rdata_o), .m_req_o(d2_m_req_o), .m_we_o(d2_m_we_o),
      .m_be_o(d2_m_be_o), .m_addr_o(d2_m_addr_o), .m_wdata_o(d2_m_wdata_o),
      .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
      .outstanding_o(d2_outstanding_o)
   );

   cnt_obi_buf #(.AW(32), .DW(32), .DEPTH(4)) u_d4 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_req_i(s_req_i), .s_we_i(s_we_i), .s_be_i(s_be_i), .s_addr_i(s_addr_i),
      .s_wdata_i(s_wdata_i), .s_gnt_o(d4_s_gnt_o), .s_rvalid_o(d4_s_rvalid_o),
      .s_rdata_o(d4_s_rdata_o), .m_req_o(d4_m_req_o), .m_we_o(d4_m_we_o),
      .m_be_o(d4_m_be_o), .m_addr_o(d4_m_addr_o), .m_wdata_o(d4_m_wdata_o),
      .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
      .outstanding_o(d4_outstanding_o)
   );

   task automatic idle_inputs();
      s_req_i    = 1'b0;
      s_we_i     = 1'b0;
      s_be_i     = '0;
      s_addr_i   = '0;
      s_wdata_i  = '0;
      m_gnt_i    = 1'b0;
      m_rvalid_i = 1'b0;
      m_rdata_i  = '0;
   endtask

   // Returns 1 time unit after a rising edge; inputs are driven here.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b1;
      #2 rst_ni = 1'b0;
      // Live inputs that would otherwise produce grant/valid must be masked.
      s_req_i = 1'b1; m_gnt_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
      next_cycle();
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", d2_s_gnt_o); end
      n_tests++;
      if (d2_m_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mreq: got %b want 0", d2_m_req_o); end
      n_tests++;
      if (d2_s_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", d2_s_rvalid_o); end
      n_tests++;
      if (d2_s_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", d2_s_rdata_o); end
      n_tests++;
      if (d2_outstanding_o !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", d2_outstanding_o); end
      n_tests++;
      if ({d2_m_addr_o, d2_m_wdata_o, d2_m_be_o, d2_m_we_o} !== 69'h0) begin
         n_fail++; $display("FAIL reset_mbus: addr %h wdata %h be %h we %b want all 0",
                            d2_m_addr_o, d2_m_wdata_o, d2_m_be_o, d2_m_we_o);
      end
   endtask

   task automatic test_single_read();
      logic [31:0] got;
      int          nv;
      apply_reset();
      s_req_i = 1'b1; s_we_i = 1'b0; s_be_i = 4'hF; s_addr_i = 32'h100; m_gnt_i = 1'b1;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", d2_s_gnt_o); end
      next_cycle();
      idle_inputs(); m_gnt_i = 1'b1;
      #1;
      n_tests++;
      if (d2_m_req_o !== 1'b1 || d2_m_addr_o !== 32'h100 || d2_m_we_o !== 1'b0) begin
         n_fail++; $display("FAIL single_mreq: req %b addr %h we %b want 1 00000100 0", d2_m_req_o, d2_m_addr_o, d2_m_we_o);
      end
      n_tests++;
      if (d2_outstanding_o !== 2'd1) begin n_fail++; $display("FAIL single_out1: got %0d want 1", d2_outstanding_o); end
      next_cycle();
      m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF;
      #1;
      n_tests++;
      if (d2_m_req_o !== 1'b0) begin n_fail++; $display("FAIL single_mreq_drop: got %b want 0", d2_m_req_o); end
      n_tests++;
      if (d2_s_rvalid_o !== BYP) begin n_fail++; $display("FAIL single_rsp_latency: rvalid %b want %b", d2_s_rvalid_o, BYP); end
      got = d2_s_rvalid_o ? d2_s_rdata_o : 32'h0;
      nv  = d2_s_rvalid_o ? 1 : 0;
      next_cycle();
      m_rvalid_i = 1'b0; m_rdata_i = '0;
      #1;
      if (d2_s_rvalid_o) begin got = d2_s_rdata_o; nv++; end
      n_tests++;
      if (nv !== 1) begin n_fail++; $display("FAIL single_rsp_count: got %0d want 1", nv); end
      n_tests++;
      if (got !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", got); end
      next_cycle();
      #1;
      n_tests++;
      if (d2_outstanding_o !== 2'd0 || d2_s_rvalid_o !== 1'b0) begin
         n_fail++; $display("FAIL single_done: outstanding %0d rvalid %b want 0 0", d2_outstanding_o, d2_s_rvalid_o);
      end
   endtask

   task automatic test_credit();
      apply_reset();
      m_gnt_i = 1'b1; s_req_i = 1'b1; s_be_i = 4'hF; s_addr_i = 32'h0;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL credit_gnt0: got %b want 1", d2_s_gnt_o); end
      next_cycle();
      s_addr_i = 32'h4;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL credit_gnt1: got %b want 1", d2_s_gnt_o); end
      next_cycle();
      s_addr_i = 32'h8;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b0) begin n_fail++; $display("FAIL credit_gnt2: got %b want 0", d2_s_gnt_o); end
      n_tests++;
      if (d2_outstanding_o !== 2'd2) begin n_fail++; $display("FAIL credit_out2: got %0d want 2", d2_outstanding_o); end
      n_tests++;
      if (d4_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL credit_d4_gnt2: got %b want 1", d4_s_gnt_o); end
      next_cycle();
      s_req_i = 1'b0;
      #1;
      n_tests++;
      if (d2_outstanding_o !== 2'd2 || d2_m_req_o !== 1'b0) begin
         n_fail++; $display("FAIL credit_hold: outstanding %0d mreq %b want 2 0", d2_outstanding_o, d2_m_req_o);
      end
      n_tests++;
      if (d4_outstanding_o !== 3'd3) begin n_fail++; $display("FAIL credit_d4_out3: got %0d want 3", d4_outstanding_o); end
   endtask

   task automatic test_stall();
      apply_reset();
      s_req_i = 1'b1; s_we_i = 1'b1; s_be_i = 4'hF; s_addr_i = 32'h40; s_wdata_i = 32'h1234_5678;
      m_gnt_i = 1'b0;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL stall_first_gnt: got %b want 1", d2_s_gnt_o); end
      next_cycle();
      // A competing request keeps trying while the slot is stalled.
      s_we_i = 1'b0; s_be_i = 4'h3; s_addr_i = 32'h80; s_wdata_i = 32'hFFFF_0000;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_tests++;
         if (d2_m_req_o !== 1'b1 || d2_m_we_o !== 1'b1 || d2_m_be_o !== 4'hF ||
             d2_m_addr_o !== 32'h40 || d2_m_wdata_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: req %b we %b be %h addr %h wdata %h want 1 1 f 00000040 12345678",
                     c, d2_m_req_o, d2_m_we_o, d2_m_be_o, d2_m_addr_o, d2_m_wdata_o);
         end
         n_tests++;
         if (d2_s_gnt_o !== 1'b0) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b want 0", c, d2_s_gnt_o); end
         next_cycle();
      end
      // Grant and new handshake in the same cycle: slot stays full with new data.
      m_gnt_i = 1'b1;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_gnt: got %b want 1", d2_s_gnt_o); end
      next_cycle();
      s_req_i = 1'b0; m_gnt_i = 1'b0;
      #1;
      n_tests++;
      if (d2_m_req_o !== 1'b1 || d2_m_addr_o !== 32'h80 || d2_m_we_o !== 1'b0 || d2_outstanding_o !== 2'd2) begin
         n_fail++; $display("FAIL stall_reload: req %b addr %h we %b outstanding %0d want 1 00000080 0 2",
                            d2_m_req_o, d2_m_addr_o, d2_m_we_o, d2_outstanding_o);
      end
   endtask

   task automatic test_order();
      int first_k = -1;
      int last_k  = -1;
      int nv      = 0;
      apply_reset();
      m_gnt_i = 1'b1; s_be_i = 4'hF;
      for (int i = 0; i < 3; i++) begin
         s_req_i = 1'b1; s_addr_i = 32'(i * 4);
         #1;
         n_tests++;
         if (d4_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL order_gnt[%0d]: got %b want 1", i, d4_s_gnt_o); end
         next_cycle();
      end
      s_req_i = 1'b0;
      #1;
      n_tests++;
      if (d4_outstanding_o !== 3'd3) begin n_fail++; $display("FAIL order_out3: got %0d want 3", d4_outstanding_o); end
      for (int k = 0; k < 6; k++) begin
         m_rvalid_i = (k < 3);
         m_rdata_i  = (k < 3) ? 32'(k + 1) : 32'h0;
         #1;
         if (d4_s_rvalid_o) begin
            if (first_k < 0) first_k = k;
            last_k = k;
            n_tests++;
            if (d4_s_rdata_o !== 32'(nv + 1)) begin
               n_fail++; $display("FAIL order_rdata[%0d]: got %h want %h", nv, d4_s_rdata_o, 32'(nv + 1));
            end
            nv++;
         end
         next_cycle();
      end
      m_rvalid_i = 1'b0;
      n_tests++;
      if (nv !== 3) begin n_fail++; $display("FAIL order_count: got %0d want 3", nv); end
      n_tests++;
      if (first_k !== (BYP ? 0 : 1)) begin n_fail++; $display("FAIL order_latency: first valid at %0d want %0d", first_k, BYP ? 0 : 1); end
      n_tests++;
      if (last_k - first_k !== 2) begin n_fail++; $display("FAIL order_contiguous: span %0d want 2", last_k - first_k); end
      #1;
      n_tests++;
      if (d4_outstanding_o !== 3'd0) begin n_fail++; $display("FAIL order_out0: got %0d want 0", d4_outstanding_o); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      s_req_i = 1'b1; s_be_i = 4'hF; s_addr_i = 32'h200; m_gnt_i = 1'b0;
      next_cycle();
      s_req_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h55;
      next_cycle();
      m_rvalid_i = 1'b0; m_rdata_i = '0;
      #1;
      n_tests++;
      if (d2_m_req_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_mreq: got %b want 1", d2_m_req_o); end
      n_tests++;
      if (d2_s_rvalid_o !== !BYP) begin n_fail++; $display("FAIL midrst_pre_rvalid: got %b want %b", d2_s_rvalid_o, !BYP); end
      n_tests++;
      if (d2_outstanding_o !== (BYP ? 2'd0 : 2'd1)) begin
         n_fail++; $display("FAIL midrst_pre_out: got %0d want %0d", d2_outstanding_o, BYP ? 0 : 1);
      end
      // Assert reset between clock edges; outputs must clear without an edge.
      #2 rst_ni = 1'b0;
      #1;
      n_tests++;
      if (d2_m_req_o !== 1'b0 || d2_s_rvalid_o !== 1'b0 || d2_outstanding_o !== 2'd0 || d2_s_gnt_o !== 1'b0) begin
         n_fail++; $display("FAIL midrst_clear: mreq %b rvalid %b outstanding %0d gnt %b want 0 0 0 0",
                            d2_m_req_o, d2_s_rvalid_o, d2_outstanding_o, d2_s_gnt_o);
      end
      next_cycle();
      rst_ni = 1'b1;
      s_req_i = 1'b1; s_addr_i = 32'h300; m_gnt_i = 1'b1;
      #1;
      n_tests++;
      if (d2_s_gnt_o !== 1'b1) begin n_fail++; $display("FAIL midrst_resume_gnt: got %b want 1", d2_s_gnt_o); end
      next_cycle();
      s_req_i = 1'b0;
      #1;
      n_tests++;
      if (d2_m_req_o !== 1'b1 || d2_m_addr_o !== 32'h300 || d2_outstanding_o !== 2'd1 || d2_s_rvalid_o !== 1'b0) begin
         n_fail++; $display("FAIL midrst_resume: mreq %b addr %h outstanding %0d rvalid %b want 1 00000300 1 0",
                            d2_m_req_o, d2_m_addr_o, d2_outstanding_o, d2_s_rvalid_o);
      end
   endtask

   task automatic test_back_to_back();
      int          issued   = 0;
      int          received = 0;
      int          extra    = 0;
      logic        rsp_pend = 1'b0;
      logic [31:0] rsp_addr = '0;
      apply_reset();
      m_gnt_i = 1'b1; s_be_i = 4'hF; s_we_i = 1'b0;
      // Downstream model: answers every granted request one cycle later with
      // data derived from the address it actually received.
      for (int cyc = 0; cyc < 200 && received < 16; cyc++) begin
         m_rvalid_i = rsp_pend;
         m_rdata_i  = rsp_pend ? (32'hA000_0000 | rsp_addr) : 32'h0;
         s_req_i    = (issued < 16);
         s_addr_i   = 32'(issued * 4);
         #1;
         if (s_req_i && d2_s_gnt_o) issued++;
         rsp_pend = d2_m_req_o && m_gnt_i;
         rsp_addr = d2_m_addr_o;
         if (d2_s_rvalid_o) begin
            n_tests++;
            if (d2_s_rdata_o !== (32'hA000_0000 | 32'(received * 4))) begin
               n_fail++; $display("FAIL stream_rdata[%0d]: got %h want %h", received, d2_s_rdata_o,
                                  32'hA000_0000 | 32'(received * 4));
            end
            received++;
         end
         next_cycle();
      end
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         #1;
         if (d2_s_rvalid_o) extra++;
         next_cycle();
      end
      n_tests++;
      if (received !== 16 || issued !== 16) begin
         n_fail++; $display("FAIL stream_count: received %0d issued %0d want 16 16", received, issued);
      end
      n_tests++;
      if (extra !== 0) begin n_fail++; $display("FAIL stream_extra: got %0d extra responses want 0", extra); end
      #1;
      n_tests++;
      if (d2_outstanding_o !== 2'd0) begin n_fail++; $display("FAIL stream_out0: got %0d want 0", d2_outstanding_o); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_credit();
      test_stall();
      test_order();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
